// File: rtl/seven_segment_scanner.sv
// ---------------------------------------------------------------------------
// seven_segment_scanner
//
// Multiplexed multi-digit hex display driver for a common-segment LED display
// with one enable line per digit.
//
// A producer offers a packed hex value, per-digit decimal points and a
// leading-zero-suppression flag over a valid/ready handshake. An accepted
// offer waits in a pending buffer and is copied into the shadow (displayed)
// copy only at a frame boundary, so one frame never mixes two values.
//
// Each digit owns a slot of SCAN_DIV cycles. The first BLANK_CYCLES cycles of
// every slot are dead time (all outputs dark) to avoid ghosting while the
// digit enables switch over.
//
// Ports:
//   clock          system clock
//   reset          asynchronous, active-high reset
//   value_valid    producer offers value / dots / blank_leading
//   value_ready    an offer is accepted on this cycle's clock edge if valid
//   value          packed nibbles, digit 0 (rightmost) in bits [3:0]
//   dots           decimal point per digit
//   blank_leading  enables leading-zero suppression
//   abcdefg        segments, active high, a = bit 6 ... g = bit 0
//   dp             decimal point, active high
//   digit_en       digit enable, active high, one-hot or all zero
//
// Every output comes straight from a flop. The output flops are loaded from
// the next-state values of the slot counter, digit index and shadow copy, so
// the registered outputs line up with the cnt register: digit_en is non-zero
// exactly in the cycles where cnt >= BLANK_CYCLES.
// ---------------------------------------------------------------------------
module seven_segment_scanner #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 12000,
  parameter int BLANK_CYCLES = 600
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  value_valid,
  output logic                  value_ready,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dots,
  input  logic                  blank_leading,
  output logic [6:0]            abcdefg,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_SHOW = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] EN_BASE  = DIGITS'(1'b1);

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------

  // Standard hex font, segment order a..g from bit 6 down to bit 0.
  function automatic logic [6:0] decode_hex(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1111110;
      4'h1:    seg = 7'b0110000;
      4'h2:    seg = 7'b1101101;
      4'h3:    seg = 7'b1111001;
      4'h4:    seg = 7'b0110011;
      4'h5:    seg = 7'b1011011;
      4'h6:    seg = 7'b1011111;
      4'h7:    seg = 7'b1110000;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1111011;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b0011111;
      4'hC:    seg = 7'b1001110;
      4'hD:    seg = 7'b0111101;
      4'hE:    seg = 7'b1001111;
      4'hF:    seg = 7'b1000111;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  // AND-OR mux selecting nibble 'sel' out of the packed value.
  function automatic logic [3:0] pick_nibble(input logic [4*DIGITS-1:0] v,
                                             input logic [IDX_W-1:0]    sel);
    logic [3:0] r;
    r = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      r = r | ({4{sel == IDX_W'(i)}} & v[4*i +: 4]);
    end
    return r;
  endfunction

  // AND-OR mux selecting bit 'sel' out of a per-digit vector.
  function automatic logic pick_bit(input logic [DIGITS-1:0] d,
                                    input logic [IDX_W-1:0]  sel);
    logic r;
    r = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      r = r | ((sel == IDX_W'(i)) & d[i]);
    end
    return r;
  endfunction

  // Digit i (i > 0) is dark when suppression is on and nibbles i..DIGITS-1
  // are all zero. Walking down from the top digit keeps a running
  // "everything above is zero" flag. Digit 0 always shows.
  function automatic logic [DIGITS-1:0] suppress_mask(input logic [4*DIGITS-1:0] v,
                                                      input logic                blank);
    logic [DIGITS-1:0] m;
    logic              upper_zero;
    m          = {DIGITS{1'b0}};
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero & (v[4*i +: 4] == 4'h0);
      m[i]       = blank & upper_zero;
    end
    return m;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0]    cnt_r;
  logic [IDX_W-1:0]    idx_r;

  logic                pending_r;
  logic [4*DIGITS-1:0] pend_value_r;
  logic [DIGITS-1:0]   pend_dots_r;
  logic                pend_blank_r;

  logic [4*DIGITS-1:0] shadow_value_r;
  logic [DIGITS-1:0]   shadow_dots_r;
  logic                shadow_blank_r;

  logic                value_ready_r;
  logic [DIGITS-1:0]   digit_en_r;
  logic [6:0]          abcdefg_r;
  logic                dp_r;

  // -------------------------------------------------------------------------
  // Next-state signals
  // -------------------------------------------------------------------------
  logic                slot_end_s;
  logic                frame_end_s;
  logic [CNT_W-1:0]    cnt_next_s;
  logic [IDX_W-1:0]    idx_next_s;

  logic                accept_s;
  logic                shadow_load_s;
  logic                pending_next_s;

  logic [4*DIGITS-1:0] shadow_value_next_s;
  logic [DIGITS-1:0]   shadow_dots_next_s;
  logic                shadow_blank_next_s;

  logic [DIGITS-1:0]   suppress_s;
  logic                show_s;
  logic [3:0]          nibble_s;
  logic [DIGITS-1:0]   digit_en_next_s;
  logic [6:0]          abcdefg_next_s;
  logic                dp_next_s;

  // Slot counter and digit index advance; detect slot and frame boundaries.
  always_comb begin
    slot_end_s  = (cnt_r == CNT_LAST);
    frame_end_s = slot_end_s & (idx_r == IDX_LAST);
    cnt_next_s  = cnt_r;
    idx_next_s  = idx_r;
    if (slot_end_s) begin
      cnt_next_s = {CNT_W{1'b0}};
      if (idx_r == IDX_LAST) begin
        idx_next_s = {IDX_W{1'b0}};
      end else begin
        idx_next_s = idx_r + IDX_W'(1'b1);
      end
    end else begin
      cnt_next_s = cnt_r + CNT_W'(1'b1);
    end
  end

  // Handshake: accept when ready, hand pending over at the frame boundary.
  // Ready is the inverse of pending, so an accept and a hand-over can never
  // happen on the same edge; an accept on the boundary edge only fills
  // pending and the shadow copy is left alone until the next boundary.
  always_comb begin
    accept_s       = value_valid & value_ready_r;
    shadow_load_s  = frame_end_s & pending_r;
    pending_next_s = pending_r;
    if (shadow_load_s) begin
      pending_next_s = 1'b0;
    end else if (accept_s) begin
      pending_next_s = 1'b1;
    end else begin
      pending_next_s = pending_r;
    end
  end

  // Shadow copy as it will be after this edge; output decode uses it so the
  // first SHOW cycle of a new frame already reflects the new value.
  always_comb begin
    shadow_value_next_s = shadow_value_r;
    shadow_dots_next_s  = shadow_dots_r;
    shadow_blank_next_s = shadow_blank_r;
    if (shadow_load_s) begin
      shadow_value_next_s = pend_value_r;
      shadow_dots_next_s  = pend_dots_r;
      shadow_blank_next_s = pend_blank_r;
    end else begin
      shadow_value_next_s = shadow_value_r;
      shadow_dots_next_s  = shadow_dots_r;
      shadow_blank_next_s = shadow_blank_r;
    end
  end

  // Output decode from next-state values, so the flopped outputs track cnt_r.
  always_comb begin
    suppress_s      = suppress_mask(shadow_value_next_s, shadow_blank_next_s);
    show_s          = (cnt_next_s >= CNT_SHOW) & ~pick_bit(suppress_s, idx_next_s);
    nibble_s        = pick_nibble(shadow_value_next_s, idx_next_s);
    digit_en_next_s = {DIGITS{1'b0}};
    abcdefg_next_s  = 7'b0000000;
    dp_next_s       = 1'b0;
    if (show_s) begin
      digit_en_next_s = EN_BASE << idx_next_s;
      abcdefg_next_s  = decode_hex(nibble_s);
      dp_next_s       = pick_bit(shadow_dots_next_s, idx_next_s);
    end else begin
      digit_en_next_s = {DIGITS{1'b0}};
      abcdefg_next_s  = 7'b0000000;
      dp_next_s       = 1'b0;
    end
  end

  // Slot counter and digit index registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
      idx_r <= {IDX_W{1'b0}};
    end else begin
      cnt_r <= cnt_next_s;
      idx_r <= idx_next_s;
    end
  end

  // Pending buffer, pending flag and registered ready.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_r     <= 1'b0;
      pend_value_r  <= {(4*DIGITS){1'b0}};
      pend_dots_r   <= {DIGITS{1'b0}};
      pend_blank_r  <= 1'b0;
      value_ready_r <= 1'b1;
    end else begin
      pending_r     <= pending_next_s;
      value_ready_r <= ~pending_next_s;
      if (accept_s) begin
        pend_value_r <= value;
        pend_dots_r  <= dots;
        pend_blank_r <= blank_leading;
      end
    end
  end

  // Shadow (displayed) copy registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_value_r <= {(4*DIGITS){1'b0}};
      shadow_dots_r  <= {DIGITS{1'b0}};
      shadow_blank_r <= 1'b0;
    end else begin
      shadow_value_r <= shadow_value_next_s;
      shadow_dots_r  <= shadow_dots_next_s;
      shadow_blank_r <= shadow_blank_next_s;
    end
  end

  // Display output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digit_en_r <= {DIGITS{1'b0}};
      abcdefg_r  <= 7'b0000000;
      dp_r       <= 1'b0;
    end else begin
      digit_en_r <= digit_en_next_s;
      abcdefg_r  <= abcdefg_next_s;
      dp_r       <= dp_next_s;
    end
  end

  assign value_ready = value_ready_r;
  assign digit_en    = digit_en_r;
  assign abcdefg     = abcdefg_r;
  assign dp          = dp_r;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// ---------------------------------------------------------------------------
// tb_seven_segment_scanner
//
// Directed bench for seven_segment_scanner with DIGITS=4, SCAN_DIV=8,
// BLANK_CYCLES=2 (32-cycle frame). Outputs are sampled 1 time unit after each
// rising edge; p is the position within the frame (cnt = p % 8, idx = p / 8),
// counted from reset release.
// ---------------------------------------------------------------------------
module tb_seven_segment_scanner;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        value_valid = 1'b0;
  logic        value_ready;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dots = 4'b0000;
  logic        blank_leading = 1'b0;
  logic [6:0]  abcdefg;
  logic        dp;
  logic [3:0]  digit_en;

  int checks = 0;
  int fails  = 0;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;

  localparam logic [27:0] SEGS_0000 = {SEG_0, SEG_0, SEG_0, SEG_0};
  localparam logic [27:0] SEGS_1234 = {SEG_1, SEG_2, SEG_3, SEG_4};
  localparam logic [27:0] SEGS_0050 = {SEG_0, SEG_0, SEG_5, SEG_0};
  localparam logic [27:0] SEGS_ABCD = {SEG_A, SEG_B, SEG_C, SEG_D};
  localparam logic [27:0] SEGS_5678 = {SEG_5, SEG_6, SEG_7, SEG_8};

  seven_segment_scanner #(
    .DIGITS(4),
    .SCAN_DIV(8),
    .BLANK_CYCLES(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .value_valid(value_valid),
    .value_ready(value_ready),
    .value(value),
    .dots(dots),
    .blank_leading(blank_leading),
    .abcdefg(abcdefg),
    .dp(dp),
    .digit_en(digit_en)
  );

  always #5 clock = ~clock;

  // Expected {digit_en, abcdefg, dp} at frame position p, given the per-digit
  // segment table (digit 3 in the top 7 bits), decimal points and which
  // digits are lit at all.
  function automatic logic [11:0] expect_out(input int p, input logic [27:0] segs,
                                             input logic [3:0] dpm, input logic [3:0] enm);
    int         c;
    int         d;
    logic [3:0] one;
    logic [11:0] r;
    c = p % 8;
    d = p / 8;
    r = 12'h000;
    if (c >= 2 && enm[d]) begin
      one = 4'b0001 << d;
      r   = {one, segs[7*d +: 7], dpm[d]};
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] exp;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({digit_en, abcdefg, dp} !== 12'h000) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected %b", {digit_en, abcdefg, dp}, 12'h000);
    end
    checks++;
    if (value_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b expected 1", value_ready);
    end
    reset = 1'b0;
    for (int p = 0; p < 32; p++) begin
      exp = expect_out(p, SEGS_0000, 4'b0000, 4'b1111);
      checks++;
      if ({digit_en, abcdefg, dp} !== exp) begin
        fails++;
        $display("FAIL idle_frame p%0d: got %b expected %b", p, {digit_en, abcdefg, dp}, exp);
      end
      checks++;
      if (value_ready !== 1'b1) begin
        fails++;
        $display("FAIL idle_ready p%0d: got %b expected 1", p, value_ready);
      end
      step();
    end
  endtask

  task automatic test_load();
    logic [11:0] exp;
    logic        exp_rdy;
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 32; p++) begin
        if (f == 0) begin
          exp     = expect_out(p, SEGS_0000, 4'b0000, 4'b1111);
          exp_rdy = (p < 6);
        end else begin
          exp     = expect_out(p, SEGS_1234, 4'b0100, 4'b1111);
          exp_rdy = 1'b1;
        end
        checks++;
        if ({digit_en, abcdefg, dp} !== exp) begin
          fails++;
          $display("FAIL load_display f%0d p%0d: got %b expected %b", f, p, {digit_en, abcdefg, dp}, exp);
        end
        checks++;
        if (value_ready !== exp_rdy) begin
          fails++;
          $display("FAIL load_ready f%0d p%0d: got %b expected %b", f, p, value_ready, exp_rdy);
        end
        if (f == 0 && p == 5) begin
          value = 16'h1234; dots = 4'b0100; blank_leading = 1'b0; value_valid = 1'b1;
        end else begin
          value_valid = 1'b0;
        end
        step();
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [11:0] exp;
    logic        exp_rdy;
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 32; p++) begin
        if (f == 0) begin
          exp     = expect_out(p, SEGS_1234, 4'b0100, 4'b1111);
          exp_rdy = (p < 11);
        end else begin
          exp     = expect_out(p, SEGS_0050, 4'b0000, 4'b0011);
          exp_rdy = (p < 4);
        end
        checks++;
        if ({digit_en, abcdefg, dp} !== exp) begin
          fails++;
          $display("FAIL lz_display f%0d p%0d: got %b expected %b", f, p, {digit_en, abcdefg, dp}, exp);
        end
        checks++;
        if (value_ready !== exp_rdy) begin
          fails++;
          $display("FAIL lz_ready f%0d p%0d: got %b expected %b", f, p, value_ready, exp_rdy);
        end
        if (f == 0 && p == 10) begin
          value = 16'h0050; dots = 4'b0000; blank_leading = 1'b1; value_valid = 1'b1;
        end else if (f == 1 && p == 3) begin
          value = 16'h0000; dots = 4'b1111; blank_leading = 1'b1; value_valid = 1'b1;
        end else begin
          value_valid = 1'b0;
        end
        step();
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp;
    logic        exp_rdy;
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 32; p++) begin
        if (f == 0) begin
          // 0000 with suppression: only digit 0 lit, its dot on.
          exp     = expect_out(p, SEGS_0000, 4'b1111, 4'b0001);
          exp_rdy = (p < 3);
        end else begin
          exp     = expect_out(p, SEGS_1234, 4'b0000, 4'b1111);
          exp_rdy = (p < 1);
        end
        checks++;
        if ({digit_en, abcdefg, dp} !== exp) begin
          fails++;
          $display("FAIL b2b_display f%0d p%0d: got %b expected %b", f, p, {digit_en, abcdefg, dp}, exp);
        end
        checks++;
        if (value_ready !== exp_rdy) begin
          fails++;
          $display("FAIL b2b_ready f%0d p%0d: got %b expected %b", f, p, value_ready, exp_rdy);
        end
        if (f == 0 && p == 2) begin
          value = 16'h1234; dots = 4'b0000; blank_leading = 1'b0; value_valid = 1'b1;
        end else if (f == 0 && p == 3) begin
          value_valid = 1'b0;
        end else if (f == 0 && p == 4) begin
          // Held through the rest of the frame and into p0 of the next.
          value = 16'hABCD; dots = 4'b1000; blank_leading = 1'b0; value_valid = 1'b1;
        end else if (f == 1 && p == 1) begin
          value_valid = 1'b0;
        end
        step();
      end
    end
  endtask

  task automatic test_boundary_collision();
    logic [11:0] exp;
    logic        exp_rdy;
    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < 32; p++) begin
        if (f < 2) begin
          exp     = expect_out(p, SEGS_ABCD, 4'b1000, 4'b1111);
          exp_rdy = (f == 0);
        end else begin
          exp     = expect_out(p, SEGS_5678, 4'b0001, 4'b1111);
          exp_rdy = 1'b1;
        end
        checks++;
        if ({digit_en, abcdefg, dp} !== exp) begin
          fails++;
          $display("FAIL bnd_display f%0d p%0d: got %b expected %b", f, p, {digit_en, abcdefg, dp}, exp);
        end
        checks++;
        if (value_ready !== exp_rdy) begin
          fails++;
          $display("FAIL bnd_ready f%0d p%0d: got %b expected %b", f, p, value_ready, exp_rdy);
        end
        if (f == 0 && p == 31) begin
          value = 16'h5678; dots = 4'b0001; blank_leading = 1'b0; value_valid = 1'b1;
        end else begin
          value_valid = 1'b0;
        end
        step();
      end
    end
  endtask

  task automatic test_reset_mid_show();
    logic [11:0] exp;
    logic        exp_rdy;
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 32; p++) begin
        if (f == 1 && p > 19) break;
        if (f == 0) begin
          exp     = expect_out(p, SEGS_5678, 4'b0001, 4'b1111);
          exp_rdy = (p < 2);
        end else begin
          exp     = expect_out(p, SEGS_1234, 4'b0100, 4'b1111);
          exp_rdy = (p < 6);
        end
        checks++;
        if ({digit_en, abcdefg, dp} !== exp) begin
          fails++;
          $display("FAIL pre_rst_display f%0d p%0d: got %b expected %b", f, p, {digit_en, abcdefg, dp}, exp);
        end
        checks++;
        if (value_ready !== exp_rdy) begin
          fails++;
          $display("FAIL pre_rst_ready f%0d p%0d: got %b expected %b", f, p, value_ready, exp_rdy);
        end
        if (f == 0 && p == 1) begin
          value = 16'h1234; dots = 4'b0100; blank_leading = 1'b0; value_valid = 1'b1;
        end else if (f == 1 && p == 5) begin
          value = 16'hFFFF; dots = 4'b1111; blank_leading = 1'b0; value_valid = 1'b1;
        end else begin
          value_valid = 1'b0;
        end
        if (!(f == 1 && p == 19)) step();
      end
    end
    // Mid digit-2 SHOW, between clock edges.
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({digit_en, abcdefg, dp} !== 12'h000) begin
      fails++;
      $display("FAIL mid_rst_outputs: got %b expected %b", {digit_en, abcdefg, dp}, 12'h000);
    end
    checks++;
    if (value_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_rst_ready: got %b expected 1", value_ready);
    end
    step();
    reset = 1'b0;
    // The pending FFFF must be gone: two frames of 0000.
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 32; p++) begin
        exp = expect_out(p, SEGS_0000, 4'b0000, 4'b1111);
        checks++;
        if ({digit_en, abcdefg, dp} !== exp) begin
          fails++;
          $display("FAIL post_rst_display f%0d p%0d: got %b expected %b", f, p, {digit_en, abcdefg, dp}, exp);
        end
        checks++;
        if (value_ready !== 1'b1) begin
          fails++;
          $display("FAIL post_rst_ready f%0d p%0d: got %b expected 1", f, p, value_ready);
        end
        step();
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_leading_zero();
    test_back_to_back();
    test_boundary_collision();
    test_reset_mid_show();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
